alu_responder: RTL and testbench
================================

# alu_responder

Handshaked, registered responder for the N-bit ALU operand interface. It accepts one operand pair plus opcode per valid/ready transfer, computes the result, and queues it in a 2-entry result buffer. Results return in order on a valid/ready response channel with a carry/borrow flag. A wrapping counter tracks completed transactions. It sits between a stimulus/initiator (bench or upstream controller) and any downstream result consumer.

## Interface
- N, default 4, operand and result width (N >= 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  initiator presents a request
- req_ready  output  1  responder can accept a request this cycle
- req_opcode  input  2  0 = ADD, 1 = OR, 2 = SUB, 3 = XOR
- req_in0  input  N  operand A
- req_in1  input  N  operand B
- rsp_valid  output  1  head result available
- rsp_ready  input  1  consumer takes the head result this cycle
- rsp_out  output  N  head result
- rsp_flag  output  1  carry (ADD) or borrow (SUB); 0 for OR and XOR
- txn_count  output  8  completed responses, modulo 256

## Operation
- **Accept:** a request transfers when req_valid && req_ready at a rising clk edge.
- **Compute:** the result is computed from the transferring operands and written into the tail of the result buffer at the same edge.
  - ADD: {rsp_flag, rsp_out} = in0 + in1, (N+1)-bit. The flag is bit N.
  - SUB: rsp_out = (in0 - in1) mod 2^N. rsp_flag = 1 iff in0 < in1 (unsigned).
  - OR: in0 | in1. XOR: in0 ^ in1. Flag = 0 for both.
- **Buffer:** 2 entries, FIFO order, occupancy count in {0, 1, 2}.
  - Encoding is free, e.g. states EMPTY, ONE, FULL.
  - Push = request transfer. Pop = rsp_valid && rsp_ready.
- **Buffer transitions:**
  - EMPTY: push -> ONE. Pop is impossible because rsp_valid = 0.
  - ONE: push only -> FULL. Pop only -> EMPTY. Push and pop together -> ONE; the new entry becomes head at the next cycle.
  - FULL: pop -> ONE. Push is impossible because req_ready = 0, even if rsp_ready = 1 in the same cycle; there is no pass-through.
- **Outputs:**
  - req_ready = (count != 2).
  - rsp_valid = (count != 0).
  - rsp_out and rsp_flag come from the head entry. They are registered and driven by no combinational path from req_*.
- **Hold rule:** while rsp_valid && !rsp_ready, rsp_out and rsp_flag stay stable.
- **Don't-care:** when count == 0, rsp_out and rsp_flag are don't-care, but must read 0 after reset.
- **txn_count:** increments by 1 on every pop and wraps 255 -> 0.
- **Invalid inputs:** req_* is ignored when req_valid = 0.

## Timing
- **Reset:** rst_n low asynchronously clears buffer count (EMPTY), storage, txn_count = 0, rsp_out = 0, rsp_flag = 0.
  - Resulting outputs: rsp_valid = 0, req_ready = 1.
  - Reset mid-transaction discards all queued results; no pop is counted.
- **Release:** first acceptance is possible at the first rising edge with rst_n high.
- **Latency:** request accepted at edge k -> rsp_valid high and result visible after edge k (same cycle as k+1 evaluation) if the buffer was empty. Otherwise the result is queued behind the head.
- **Throughput:** with rsp_ready held 1, one request per cycle is sustained. The occupancy oscillates ONE <-> ONE and req_ready never drops.
- **Backpressure:** with rsp_ready = 0, exactly two requests are accepted and req_ready falls low the cycle after the second acceptance.
- **Counter update:** txn_count updates at the same edge as the pop.

## Test plan
- **Reset values:** assert rst_n = 0 mid-cycle with 2 entries queued -> immediately rsp_valid = 0, req_ready = 1, txn_count = 0, rsp_out = 0. After release, no stale result appears.
- **All opcodes, N = 4, rsp_ready = 1:**
  - ADD 9 + 8 -> rsp_out 1, flag 1.
  - SUB 3 - 5 -> rsp_out 14, flag 1.
  - OR 0xA | 0x5 -> 0xF, flag 0.
  - XOR 0xC ^ 0xA -> 0x6, flag 0.
  - Each result appears one cycle after its acceptance.
- **Backpressure:** rsp_ready = 0, req_valid = 1 continuously with XOR requests (1, 2) and (3, 4), then more.
  - Exactly 2 accepted; req_ready = 0 from the cycle after the second acceptance.
  - rsp_out holds 3 while stalled. Raise rsp_ready -> outputs 3 then 7, in order.
- **Simultaneous push/pop in ONE state:** rsp_out updates to the new request's result next cycle, count stays 1, txn_count +1.
- **Wrap and random:** 300 random transfers with random req_valid/rsp_ready, compared in order against a reference queue model. Final txn_count = 300 mod 256 = 44, with no mismatch.

Source files
------------

// File: rtl/alu_responder.sv
`default_nettype none
// ============================================================================
// Module      : alu_responder
// Description : Handshaked N-bit ALU responder. Accepts one operand pair and
//               opcode per req_valid/req_ready transfer, computes the result,
//               and queues it in a 2-entry in-order result buffer. The head
//               result is presented on a rsp_valid/rsp_ready channel with a
//               carry/borrow flag. A wrapping 8-bit counter tracks pops.
// Ports       : clk, rst_n            clock, async active-low reset
//               req_valid/req_ready   request handshake
//               req_opcode            0 ADD, 1 OR, 2 SUB, 3 XOR
//               req_in0/req_in1       operands A/B (N bits)
//               rsp_valid/rsp_ready   response handshake
//               rsp_out/rsp_flag      head result and carry/borrow
//               txn_count             completed responses modulo 256
// Revision    : 1.0 - initial release
// ============================================================================
module alu_responder #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_opcode,
  input  logic [N-1:0] req_in0,
  input  logic [N-1:0] req_in1,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_out,
  output logic         rsp_flag,
  output logic [7:0]   txn_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state_q;
  // Buffer entries are {flag, result}; head_q is always the oldest entry so
  // the response outputs come straight from a flop.
  logic [N:0]   head_q;
  logic [N:0]   tail_q;
  logic [7:0]   txn_q;
  logic [N:0]   res_d;
  logic         push;
  logic         pop;

  // The (N+1)-bit subtraction leaves bit N set exactly when in0 < in1, which
  // is the borrow flag; for ADD bit N is the carry.
  always_comb begin
    res_d = '0;
    case (req_opcode)
      2'd0:    res_d = {1'b0, req_in0} + {1'b0, req_in1};
      2'd1:    res_d = {1'b0, req_in0 | req_in1};
      2'd2:    res_d = {1'b0, req_in0} - {1'b0, req_in1};
      default: res_d = {1'b0, req_in0 ^ req_in1};
    endcase
  end

  assign req_ready = (state_q != FULL);
  assign rsp_valid = (state_q != EMPTY);
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      txn_q   <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_q  <= res_d;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            tail_q  <= res_d;
            state_q <= FULL;
          end else if (!push && pop) begin
            state_q <= EMPTY;
          end else if (push && pop) begin
            // Head leaves and the new result takes its place directly.
            head_q  <= res_d;
          end
        end
        FULL: begin
          // No push here: req_ready is low, so no pass-through exists.
          if (pop) begin
            head_q  <= tail_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
      if (pop) begin
        txn_q <= txn_q + 8'd1;
      end
    end
  end

  assign rsp_out   = head_q[N-1:0];
  assign rsp_flag  = head_q[N];
  assign txn_count = txn_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_responder
// Description : Self-checking bench for alu_responder: reset values, every
//               opcode, backpressure, simultaneous push/pop, mid-transfer
//               reset and a random in-order run against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_responder;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_opcode;
  logic [N-1:0] req_in0;
  logic [N-1:0] req_in1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_out;
  logic         rsp_flag;
  logic [7:0]   txn_count;

  int checks = 0;
  int errors = 0;

  alu_responder #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_in0    (req_in0),
    .req_in1    (req_in1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_out    (rsp_out),
    .rsp_flag   (rsp_flag),
    .txn_count  (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are examined 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b);
    req_valid  = v;
    req_opcode = op;
    req_in0    = a;
    req_in1    = b;
  endtask

  // Reference: {flag, result} from the operation definitions.
  function automatic logic [N:0] model(input logic [1:0] op, input logic [N-1:0] a,
                                       input logic [N-1:0] b);
    logic [N:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = {1'b0, a | b};
      2'd2:    r = {(a < b), N'(a - b)};
      default: r = {1'b0, a ^ b};
    endcase
    return r;
  endfunction

  logic [N:0] q[$];
  logic [N:0] exp_e;
  logic       push_m;
  logic       pop_m;
  int         pops;
  int         cyc;

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    drive(1'b0, 2'd0, '0, '0);
    repeat (3) step();
    rst_n = 1'b1;

    // ---- reset values
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_txn_count", txn_count, 0);
    check("rst_rsp_out",   rsp_out,   0);
    check("rst_rsp_flag",  rsp_flag,  0);

    // ---- all opcodes with rsp_ready = 1 (also push+pop in ONE)
    rsp_ready = 1'b1;
    drive(1'b1, 2'd0, 4'd9, 4'd8);
    step();
    check("add_valid", rsp_valid, 1);
    check("add_out",   rsp_out,   1);
    check("add_flag",  rsp_flag,  1);
    check("add_txn",   txn_count, 0);
    drive(1'b1, 2'd2, 4'd3, 4'd5);
    step();
    check("sub_out",   rsp_out,   14);
    check("sub_flag",  rsp_flag,  1);
    check("sub_txn",   txn_count, 1);
    check("sub_ready", req_ready, 1);
    drive(1'b1, 2'd1, 4'hA, 4'h5);
    step();
    check("or_out",  rsp_out,   4'hF);
    check("or_flag", rsp_flag,  0);
    check("or_txn",  txn_count, 2);
    drive(1'b1, 2'd3, 4'hC, 4'hA);
    step();
    check("xor_out",   rsp_out,   4'h6);
    check("xor_flag",  rsp_flag,  0);
    check("xor_txn",   txn_count, 3);
    check("xor_valid", rsp_valid, 1);
    drive(1'b0, 2'd0, 4'hF, 4'hF);
    step();
    check("drain_valid", rsp_valid, 0);
    check("drain_txn",   txn_count, 4);
    check("drain_ready", req_ready, 1);

    // ---- backpressure
    rsp_ready = 1'b0;
    drive(1'b1, 2'd3, 4'd1, 4'd2);
    check("bp_ready0", req_ready, 1);
    step();
    check("bp_out1",    rsp_out,   3);
    check("bp_ready1",  req_ready, 1);
    drive(1'b1, 2'd3, 4'd3, 4'd4);
    step();
    check("bp_ready2",  req_ready, 0);
    check("bp_hold2",   rsp_out,   3);
    drive(1'b1, 2'd3, 4'd5, 4'd6);
    step();
    check("bp_ready3",  req_ready, 0);
    check("bp_hold3",   rsp_out,   3);
    check("bp_txn3",    txn_count, 4);
    step();
    check("bp_hold4",   rsp_out,   3);
    drive(1'b0, 2'd0, '0, '0);
    rsp_ready = 1'b1;
    step();
    check("bp_pop1_out",   rsp_out,   7);
    check("bp_pop1_txn",   txn_count, 5);
    check("bp_pop1_ready", req_ready, 1);
    step();
    check("bp_pop2_valid", rsp_valid, 0);
    check("bp_pop2_txn",   txn_count, 6);

    // ---- asynchronous reset with two entries queued
    rsp_ready = 1'b0;
    drive(1'b1, 2'd0, 4'd7, 4'd7);
    step();
    step();
    drive(1'b0, 2'd0, '0, '0);
    check("prerst_ready", req_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_req_ready", req_ready, 1);
    check("arst_txn",       txn_count, 0);
    check("arst_rsp_out",   rsp_out,   0);
    check("arst_rsp_flag",  rsp_flag,  0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    step();
    check("post_rst_valid", rsp_valid, 0);
    check("post_rst_txn",   txn_count, 0);

    // ---- random in-order run against a queue model (txn_count starts at 0)
    pops = 0;
    cyc  = 0;
    q.delete();
    while (pops < 300 && cyc < 5000) begin
      check("rnd_valid", rsp_valid, (q.size() != 0));
      check("rnd_ready", req_ready, (q.size() != 2));
      if (q.size() != 0) begin
        exp_e = q[0];
        check("rnd_out",  rsp_out,  exp_e[N-1:0]);
        check("rnd_flag", rsp_flag, exp_e[N]);
      end
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            N'($urandom_range(0, 15)), N'($urandom_range(0, 15)));
      rsp_ready = 1'($urandom_range(0, 1));
      push_m = req_valid && (q.size() != 2);
      pop_m  = rsp_ready && (q.size() != 0);
      exp_e  = model(req_opcode, req_in0, req_in1);
      step();
      if (pop_m) begin
        void'(q.pop_front());
        pops++;
      end
      if (push_m) q.push_back(exp_e);
      cyc++;
    end
    check("rnd_budget", (cyc < 5000), 1);
    check("rnd_txn_final", txn_count, 44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
